// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 8-bit CPU control path.
//   - opcode_e     : instruction class taken from ir[7:6]
//   - seq_state_e  : control_sequencer FSM states
//   - register index constants and condition codes
package cpu_pkg;

  typedef enum logic [1:0] {
    OP_IMMEDIATE = 2'b00,
    OP_COMPUTE   = 2'b01,
    OP_COPY      = 2'b10,
    OP_CONDITION = 2'b11
  } opcode_e;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_EXECUTE,
    ST_IN_WAIT,
    ST_OUT_WAIT,
    ST_HALT
  } seq_state_e;

  localparam logic [2:0] REG_CONST   = 3'd0;
  localparam logic [2:0] REG_ALU_A   = 3'd1;
  localparam logic [2:0] REG_ALU_B   = 3'd2;
  localparam logic [2:0] REG_RESULT  = 3'd3;
  localparam logic [2:0] REG_GP_A    = 3'd4;
  localparam logic [2:0] REG_GP_B    = 3'd5;
  localparam logic [2:0] SEL_IO      = 3'd6;
  localparam logic [2:0] SEL_INVALID = 3'd7;

  localparam logic [2:0] CC_NEVER  = 3'b000;
  localparam logic [2:0] CC_EQZ    = 3'b001;
  localparam logic [2:0] CC_LTZ    = 3'b010;
  localparam logic [2:0] CC_LEZ    = 3'b011;
  localparam logic [2:0] CC_ALWAYS = 3'b100;
  localparam logic [2:0] CC_NEZ    = 3'b101;
  localparam logic [2:0] CC_GEZ    = 3'b110;
  localparam logic [2:0] CC_GTZ    = 3'b111;

endpackage

// File: rtl/condition_eval.sv
// condition_eval: combinational branch condition evaluation.
// Ports:
//   i_cc      in  3  condition code
//   i_operand in  8  operand, interpreted as signed
//   o_taken   out 1  branch taken
module condition_eval
  import cpu_pkg::*;
(
  input  logic [2:0] i_cc,
  input  logic [7:0] i_operand,
  output logic       o_taken
);

  logic w_zero;
  logic w_neg;

  assign w_zero = (i_operand == '0);
  assign w_neg  = i_operand[7];

  always_comb begin
    o_taken = 1'b0;
    unique case (i_cc)
      CC_NEVER:  o_taken = 1'b0;
      CC_EQZ:    o_taken = w_zero;
      CC_LTZ:    o_taken = w_neg;
      CC_LEZ:    o_taken = w_neg | w_zero;
      CC_ALWAYS: o_taken = 1'b1;
      CC_NEZ:    o_taken = ~w_zero;
      CC_GEZ:    o_taken = ~w_neg;
      CC_GTZ:    o_taken = ~w_neg & ~w_zero;
      default:   o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: fetch/execute sequencer and register-file initiator.
// Fetches over imem req/ack, executes IMMEDIATE / COMPUTE / COPY / CONDITION,
// and optionally moves bytes through an external I/O port (index 6).
// Macro CONTROL_SEQUENCER_IO_EN: builds the I/O port; when undefined any
// COPY touching index 6 halts and in_ready/out_valid/out_data are 0.
// Ports:
//   clock, reset                      clock, synchronous active-high reset
//   imem_addr/imem_req/imem_ack/imem_data   instruction fetch
//   save/saveselector/savebus          register write
//   loadselector/loadbus               register read
//   condoperand                        register 3 contents
//   alu_op/alu_out                     ALU select / result
//   in_data/in_valid/in_ready          input stream
//   out_data/out_valid/out_ready       output stream
//   halted                             illegal instruction seen
module control_sequencer
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
)(
  input  logic       clock,
  input  logic       reset,
  output logic [7:0] imem_addr,
  output logic       imem_req,
  input  logic       imem_ack,
  input  logic [7:0] imem_data,
  output logic       save,
  output logic [2:0] saveselector,
  output logic [7:0] savebus,
  output logic [2:0] loadselector,
  input  logic [7:0] loadbus,
  input  logic [7:0] condoperand,
  output logic [2:0] alu_op,
  input  logic [7:0] alu_out,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       halted
);

  seq_state_e r_state, w_state_next;
  logic [7:0] r_pc, w_pc_next, w_pc_inc;
  logic [7:0] r_ir, w_ir_next;
  logic [2:0] w_src, w_dst;
  opcode_e    w_opcode;
  logic       w_taken;

`ifdef CONTROL_SEQUENCER_IO_EN
  logic [7:0] r_out_data;
  logic       w_out_load;
  assign out_data = r_out_data;
`else
  logic w_unused_io;
  assign w_unused_io = ^{in_data, in_valid, out_ready};
  assign out_data    = '0;
`endif

  assign w_opcode = opcode_e'(r_ir[7:6]);
  assign w_src    = r_ir[5:3];
  assign w_dst    = r_ir[2:0];
  assign w_pc_inc = r_pc + 8'd1;
  assign alu_op   = r_ir[2:0];

  condition_eval u_condition_eval (
    .i_cc      (r_ir[2:0]),
    .i_operand (condoperand),
    .o_taken   (w_taken)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
`ifdef CONTROL_SEQUENCER_IO_EN
      r_out_data <= '0;
`endif
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_ir    <= w_ir_next;
`ifdef CONTROL_SEQUENCER_IO_EN
      if (w_out_load) r_out_data <= loadbus;
`endif
    end
  end

  // Outputs are gated by reset so a state left over from before reset
  // cannot produce a partial save or a request while reset is held.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_ir_next    = r_ir;
    imem_addr    = r_pc;
    imem_req     = 1'b0;
    save         = 1'b0;
    saveselector = '0;
    savebus      = '0;
    loadselector = '0;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    halted       = 1'b0;
`ifdef CONTROL_SEQUENCER_IO_EN
    w_out_load   = 1'b0;
`endif
    if (!reset) begin
      unique case (r_state)
        ST_FETCH: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            w_ir_next    = imem_data;
            w_state_next = ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          w_state_next = ST_FETCH;
          w_pc_next    = w_pc_inc;
          unique case (w_opcode)
            OP_IMMEDIATE: begin
              save         = 1'b1;
              saveselector = REG_CONST;
              savebus      = {2'b00, r_ir[5:0]};
            end
            OP_COMPUTE: begin
              save         = 1'b1;
              saveselector = REG_RESULT;
              savebus      = alu_out;
            end
            OP_COPY: begin
              if (w_src == SEL_INVALID || w_dst == SEL_INVALID) begin
                w_state_next = ST_HALT;
                w_pc_next    = r_pc;
              end else if (w_src != SEL_IO && w_dst != SEL_IO) begin
                loadselector = w_src;
                save         = 1'b1;
                saveselector = w_dst;
                savebus      = loadbus;
`ifdef CONTROL_SEQUENCER_IO_EN
              end else if (w_dst != SEL_IO) begin
                w_state_next = ST_IN_WAIT;
                w_pc_next    = r_pc;
              end else if (w_src != SEL_IO) begin
                loadselector = w_src;
                w_out_load   = 1'b1;
                w_state_next = ST_OUT_WAIT;
                w_pc_next    = r_pc;
`endif
              end else begin
                w_state_next = ST_HALT;
                w_pc_next    = r_pc;
              end
            end
            OP_CONDITION: begin
              loadselector = REG_CONST;
              if (w_taken) w_pc_next = loadbus;
            end
            default: ;
          endcase
        end
`ifdef CONTROL_SEQUENCER_IO_EN
        ST_IN_WAIT: begin
          in_ready     = 1'b1;
          saveselector = w_dst;
          if (in_valid) begin
            save         = 1'b1;
            savebus      = in_data;
            w_pc_next    = w_pc_inc;
            w_state_next = ST_FETCH;
          end
        end
        ST_OUT_WAIT: begin
          out_valid = 1'b1;
          if (out_ready) begin
            w_pc_next    = w_pc_inc;
            w_state_next = ST_FETCH;
          end
        end
`endif
        ST_HALT: halted = 1'b1;
        default: w_state_next = ST_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] imem_addr;
  logic       imem_req;
  logic       imem_ack;
  logic [7:0] imem_data;
  logic       save;
  logic [2:0] saveselector;
  logic [7:0] savebus;
  logic [2:0] loadselector;
  logic [7:0] loadbus;
  logic [7:0] condoperand;
  logic [2:0] alu_op;
  logic [7:0] alu_out;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       halted;

  always #5 clock = ~clock;

  control_sequencer #(.RESET_PC(8'h00)) dut (
    .clock(clock), .reset(reset),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
    .save(save), .saveselector(saveselector), .savebus(savebus),
    .loadselector(loadselector), .loadbus(loadbus), .condoperand(condoperand),
    .alu_op(alu_op), .alu_out(alu_out),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .halted(halted)
  );

  // Environment: program memory with programmable ack delay, register file.
  logic [7:0] imem [256];
  logic [7:0] regs [8];
  logic [7:0] pre  [8];
  logic       do_load = 1'b0;
  int         ack_delay = 0;
  int         wait_cnt = 0;
  int         save_cnt = 0;
  logic [2:0] last_sel = '0;
  logic [7:0] last_bus = '0;

  assign imem_ack    = imem_req && (wait_cnt >= ack_delay);
  assign imem_data   = imem[imem_addr];
  assign loadbus     = regs[loadselector];
  assign condoperand = regs[3];

  always @(posedge clock) begin
    wait_cnt <= (imem_req && !imem_ack) ? wait_cnt + 1 : 0;
    if (do_load) begin
      for (int i = 0; i < 8; i++) regs[i] <= pre[i];
    end else if (save) begin
      regs[saveselector] <= savebus;
    end
    if (save) begin
      save_cnt <= save_cnt + 1;
      last_sel <= saveselector;
      last_bus <= savebus;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] instr;
    logic [7:0] alu;
    logic [7:0] r3;
    logic       exp_save;
    logic [2:0] exp_sel;
    logic [7:0] exp_bus;
    logic [7:0] exp_pc;
    logic       exp_halt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [7:0] instr, input logic [7:0] alu, input logic [7:0] r3,
                     input logic es, input logic [2:0] sel, input logic [7:0] bus,
                     input logic [7:0] pc, input logic eh);
    vec_t v;
    v.instr = instr; v.alu = alu; v.r3 = r3; v.exp_save = es; v.exp_sel = sel;
    v.exp_bus = bus; v.exp_pc = pc; v.exp_halt = eh;
    vecs.push_back(v);
  endtask

  // Holds reset for one cycle while loading registers, releases on a negedge.
  task automatic start(input logic [7:0] r0val, input logic [7:0] r3val, input int delay);
    @(negedge clock);
    reset = 1'b1; ack_delay = delay; in_valid = 1'b0; out_ready = 1'b0;
    pre[0] = r0val; pre[1] = 8'h11; pre[2] = 8'h22; pre[3] = r3val;
    pre[4] = 8'h44; pre[5] = 8'h55; pre[6] = 8'h00; pre[7] = 8'h00;
    do_load = 1'b1;
    @(posedge clock);
    @(negedge clock);
    do_load = 1'b0;
    reset = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int base;
    reset = 1'b1; alu_out = '0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 256; i++) imem[i] = 8'h00;
    for (int i = 0; i < 8; i++) pre[i] = 8'h00;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_save", {7'd0, save}, 8'h00);
    chk("rst_req", {7'd0, imem_req}, 8'h00);
    chk("rst_in_ready", {7'd0, in_ready}, 8'h00);
    chk("rst_out_valid", {7'd0, out_valid}, 8'h00);
    chk("rst_halted", {7'd0, halted}, 8'h00);
    chk("rst_addr", imem_addr, 8'h00);
    chk("rst_out_data", out_data, 8'h00);

    // Single-instruction table: regs = {10,11,22,r3,44,55,0,0}
    add(8'h05, 8'h00, 8'h00, 1, 3'd0, 8'h05, 8'h01, 0);
    add(8'h3F, 8'h00, 8'h00, 1, 3'd0, 8'h3F, 8'h01, 0);
    add(8'h42, 8'h3C, 8'h00, 1, 3'd3, 8'h3C, 8'h01, 0);
    add(8'h8C, 8'h00, 8'h00, 1, 3'd4, 8'h11, 8'h01, 0);
    add(8'h92, 8'h00, 8'h00, 1, 3'd2, 8'h22, 8'h01, 0);
    add(8'hC1, 8'h00, 8'h00, 0, 3'd0, 8'h00, 8'h10, 0);
    add(8'hC1, 8'h00, 8'h01, 0, 3'd0, 8'h00, 8'h01, 0);
    add(8'hC2, 8'h00, 8'h80, 0, 3'd0, 8'h00, 8'h10, 0);
    add(8'hC2, 8'h00, 8'h00, 0, 3'd0, 8'h00, 8'h01, 0);
    add(8'hC3, 8'h00, 8'h00, 0, 3'd0, 8'h00, 8'h10, 0);
    add(8'hC0, 8'h00, 8'h00, 0, 3'd0, 8'h00, 8'h01, 0);
    add(8'hC4, 8'h00, 8'h01, 0, 3'd0, 8'h00, 8'h10, 0);
    add(8'hC5, 8'h00, 8'h00, 0, 3'd0, 8'h00, 8'h01, 0);
    add(8'hC6, 8'h00, 8'h80, 0, 3'd0, 8'h00, 8'h01, 0);
    add(8'hC6, 8'h00, 8'h00, 0, 3'd0, 8'h00, 8'h10, 0);
    add(8'hC7, 8'h00, 8'h01, 0, 3'd0, 8'h00, 8'h10, 0);
    add(8'hC7, 8'h00, 8'hFF, 0, 3'd0, 8'h00, 8'h01, 0);
    add(8'hBF, 8'h00, 8'h00, 0, 3'd0, 8'h00, 8'h00, 1);
    add(8'hB8, 8'h00, 8'h00, 0, 3'd0, 8'h00, 8'h00, 1);
    add(8'hB6, 8'h00, 8'h00, 0, 3'd0, 8'h00, 8'h00, 1);
`ifndef CONTROL_SEQUENCER_IO_EN
    add(8'hB4, 8'h00, 8'h00, 0, 3'd0, 8'h00, 8'h00, 1);
    add(8'h96, 8'h00, 8'h00, 0, 3'd0, 8'h00, 8'h00, 1);
`endif

    foreach (vecs[i]) begin
      imem[0] = vecs[i].instr;
      alu_out = vecs[i].alu;
      start(8'h10, vecs[i].r3, 0);
      base = save_cnt;
      cyc();
      cyc();
      chk($sformatf("v%0d_saves", i), 8'(save_cnt - base), {7'd0, vecs[i].exp_save});
      if (vecs[i].exp_save) begin
        chk($sformatf("v%0d_sel", i), {5'd0, last_sel}, {5'd0, vecs[i].exp_sel});
        chk($sformatf("v%0d_bus", i), last_bus, vecs[i].exp_bus);
      end
      chk($sformatf("v%0d_pc", i), imem_addr, vecs[i].exp_pc);
      chk($sformatf("v%0d_halted", i), {7'd0, halted}, {7'd0, vecs[i].exp_halt});
      chk($sformatf("v%0d_req", i), {7'd0, imem_req}, {7'd0, !vecs[i].exp_halt});
    end

    // Two-instruction program with zero-wait memory
    imem[0] = 8'h05; imem[1] = 8'h81;
    start(8'h10, 8'h00, 0);
    cyc();
    chk("prog_save0", {7'd0, save}, 8'h01);
    chk("prog_sel0", {5'd0, saveselector}, 8'h00);
    chk("prog_bus0", savebus, 8'h05);
    cyc();
    chk("prog_addr1", imem_addr, 8'h01);
    chk("prog_nosave_fetch", {7'd0, save}, 8'h00);
    cyc();
    chk("prog_save1", {7'd0, save}, 8'h01);
    chk("prog_sel1", {5'd0, saveselector}, 8'h01);
    chk("prog_bus1", savebus, 8'h05);
    cyc();
    chk("prog_addr2", imem_addr, 8'h02);
    chk("prog_reg1", regs[1], 8'h05);

    // COMPUTE drives alu_op from ir[2:0]
    imem[0] = 8'h42; alu_out = 8'h3C;
    start(8'h10, 8'h00, 0);
    base = save_cnt;
    cyc();
    chk("alu_op", {5'd0, alu_op}, 8'h02);
    cyc();
    chk("alu_one_save", 8'(save_cnt - base), 8'h01);
    chk("alu_reg3", regs[3], 8'h3C);

    // Ack delayed by 4 cycles: address held, no save
    imem[0] = 8'h05; imem[1] = 8'h00;
    start(8'h10, 8'h00, 4);
    #1;
    base = save_cnt;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("dly%0d_req", k), {7'd0, imem_req}, 8'h01);
      chk($sformatf("dly%0d_addr", k), imem_addr, 8'h00);
      chk($sformatf("dly%0d_save", k), {7'd0, save}, 8'h00);
      cyc();
    end
    chk("dly_nosave_ack", 8'(save_cnt - base), 8'h00);
    cyc();
    chk("dly_exec_save", {7'd0, save}, 8'h01);
    chk("dly_exec_bus", savebus, 8'h05);

    // PC wrap: jump to FF, execute IMMEDIATE there, next fetch at 00
    imem[0] = 8'hC4; imem[8'hFF] = 8'h07;
    start(8'hFF, 8'h00, 0);
    cyc(); cyc();
    chk("wrap_at_ff", imem_addr, 8'hFF);
    cyc();
    chk("wrap_save", {7'd0, save}, 8'h01);
    cyc();
    chk("wrap_addr0", imem_addr, 8'h00);
    chk("wrap_reg0", regs[0], 8'h07);

    // Illegal instruction stays halted with no requests
    imem[0] = 8'hBF;
    start(8'h10, 8'h00, 0);
    cyc(); cyc();
    base = save_cnt;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("halt%0d_req", k), {7'd0, imem_req}, 8'h00);
      chk($sformatf("halt%0d_flag", k), {7'd0, halted}, 8'h01);
    end
    chk("halt_nosave", 8'(save_cnt - base), 8'h00);

`ifdef CONTROL_SEQUENCER_IO_EN
    // Input copy into reg4, in_valid arrives after 3 waiting cycles
    imem[0] = 8'hB4; imem[1] = 8'h00;
    start(8'h10, 8'h00, 0);
    cyc();
    chk("in_exec_ready", {7'd0, in_ready}, 8'h00);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("in%0d_ready", k), {7'd0, in_ready}, 8'h01);
      chk($sformatf("in%0d_save", k), {7'd0, save}, 8'h00);
    end
    in_data = 8'hA5; in_valid = 1'b1;
    #1;
    chk("in_save", {7'd0, save}, 8'h01);
    chk("in_sel", {5'd0, saveselector}, 8'h04);
    chk("in_bus", savebus, 8'hA5);
    cyc();
    in_valid = 1'b0;
    chk("in_reg4", regs[4], 8'hA5);
    chk("in_ready_drop", {7'd0, in_ready}, 8'h00);
    chk("in_addr", imem_addr, 8'h01);

    // Output copy from reg2, held until out_ready
    imem[0] = 8'h96;
    start(8'h10, 8'h00, 0);
    cyc();
    chk("out_exec_valid", {7'd0, out_valid}, 8'h00);
    cyc();
    pre[2] = 8'h99; do_load = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("out%0d_valid", k), {7'd0, out_valid}, 8'h01);
      chk($sformatf("out%0d_data", k), out_data, 8'h22);
      cyc();
    end
    do_load = 1'b0;
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("out_valid_drop", {7'd0, out_valid}, 8'h00);
    chk("out_addr", imem_addr, 8'h01);

    // Reset during OUT_WAIT drops the transfer
    imem[0] = 8'h96;
    start(8'h10, 8'h00, 0);
    cyc(); cyc();
    chk("rout_valid", {7'd0, out_valid}, 8'h01);
    reset = 1'b1;
    cyc();
    chk("rout_valid_rst", {7'd0, out_valid}, 8'h00);
    chk("rout_data_rst", out_data, 8'h00);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rout_req", {7'd0, imem_req}, 8'h01);
    chk("rout_addr", imem_addr, 8'h00);
`else
    // I/O port absent: outputs tied low even after an index-6 copy
    imem[0] = 8'h96;
    start(8'h10, 8'h00, 0);
    cyc(); cyc();
    chk("noio_valid", {7'd0, out_valid}, 8'h00);
    chk("noio_data", out_data, 8'h00);
    chk("noio_halt", {7'd0, halted}, 8'h01);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
